hazard_unit_mc: RTL

Second-generation hazard and forwarding controller for the 5-stage RV32 pipeline, extended with a multi-cycle M-extension (mul/div) execute handshake and data-memory wait-state support.
- Keeps the existing forwarding rules.
- Keeps load-use stalling, now gated on Rd != x0.
- Keeps branch/jump flushing.
- Adds a sequential mul/div busy FSM with latency counter.
- Adds a memory-wait freeze.
- Adds saturating stall/flush performance counters.
Sits beside the pipeline registers; drives all per-stage stall/flush enables.

---
 rtl/hazard_pkg.sv | 8 +
 rtl/hazard_unit_mc_sat_counter.sv | 13 +
 rtl/hazard_unit_mc.sv | 92 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the multi-cycle hazard/forwarding controller
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] RES_LOAD     = 2'b01;
endpackage

// File: rtl/hazard_unit_mc_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value <= '0;
        else if (inc && value != '1) value <= value + 1'b1;
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline forwarding, stall/flush control with mul/div busy FSM
// and data-memory wait-state freeze.
module hazard_unit_mc #(
    parameter int         REG_W      = 5,
    parameter int         MD_LATENCY = 32,
    parameter int         CNT_W      = 32,
    parameter logic [1:0] RES_LOAD   = hazard_pkg::RES_LOAD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       PCSrcE,
    input  logic             MdOpE,
    input  logic [REG_W-1:0] RdM,
    input  logic             RegWriteM,
    input  logic             DMemReadyM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdStart,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    import hazard_pkg::*;

    localparam int CW = $clog2(MD_LATENCY);

    md_state_t     state;
    logic [CW-1:0] count;
    logic          lw_stall, mem_stall, md_hold, bj;

    function automatic fwd_sel_t fwd(input logic [REG_W-1:0] rs);
        return (rs == RdM && RegWriteM && rs != '0) ? FWD_M :
               (rs == RdW && RegWriteW && rs != '0) ? FWD_W : FWD_RF;
    endfunction

    assign ForwardAE = fwd(Rs1E);
    assign ForwardBE = fwd(Rs2E);

    assign lw_stall  = ResultSrcE == RES_LOAD && RdE != '0 && (Rs1D == RdE || Rs2D == RdE);
    assign mem_stall = !DMemReadyM;
    assign bj        = PCSrcE == PCSRC_BRANCH || PCSrcE == PCSRC_JUMP;
    assign md_hold   = (state == MD_IDLE && MdOpE) || state == MD_BUSY || (state == MD_DONE && mem_stall);
    assign MdStart   = state == MD_IDLE && MdOpE && !mem_stall;
    assign MdBusy    = state == MD_BUSY;

    // Memory wait outranks mul/div hold, which outranks load-use and redirects.
    assign StallF = mem_stall || md_hold || lw_stall;
    assign StallD = StallF;
    assign StallE = mem_stall || md_hold;
    assign StallM = mem_stall;
    assign FlushW = mem_stall;
    assign FlushM = !mem_stall && md_hold;
    assign FlushD = !mem_stall && !md_hold && bj;
    assign FlushE = !mem_stall && !md_hold && (lw_stall || bj);

    // Start cycle plus MD_LATENCY-1 BUSY cycles gives MD_LATENCY stall cycles.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: if (MdStart) begin
                    count <= CW'(MD_LATENCY - 2);
                    state <= MD_BUSY;
                end
                MD_BUSY: if (count == '0) state <= MD_DONE;
                         else count <= count - 1'b1;
                MD_DONE: if (!mem_stall) state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(StallF), .value(StallCount));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(FlushD || FlushE), .value(FlushCount));
endmodule
